// File: rtl/shift_ctrl.sv
// Shift-register control front end: a prescaled shift strobe plus a
// debounced push-button that flips the shift direction.
module shift_ctrl #(
    parameter int unsigned NB_COUNT  = 32,
    parameter int unsigned LIMIT0    = 32'd1 << 23,
    parameter int unsigned LIMIT1    = 32'd1 << 24,
    parameter int unsigned LIMIT2    = 32'd1 << 25,
    parameter int unsigned LIMIT3    = 32'd1 << 26,
    parameter int unsigned DB_CYCLES = 32'd1 << 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_sw,
    input  logic       i_btn,
    output logic       o_valid,
    output logic       o_dir
);

    typedef logic [NB_COUNT-1:0] cnt_t;

    localparam cnt_t LAST0   = cnt_t'(LIMIT0 - 1);
    localparam cnt_t LAST1   = cnt_t'(LIMIT1 - 1);
    localparam cnt_t LAST2   = cnt_t'(LIMIT2 - 1);
    localparam cnt_t LAST3   = cnt_t'(LIMIT3 - 1);
    localparam cnt_t DB_LAST = cnt_t'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRESS = 3'd1,
        TOGGLE     = 3'd2,
        HELD       = 3'd3,
        WAIT_REL   = 3'd4
    } db_state_t;

    logic       btn_m_q;
    logic       btn_s_q;
    logic [1:0] sel_q;
    cnt_t       cnt_q;
    cnt_t       cnt_d;
    logic       valid_q;
    logic       valid_d;
    cnt_t       lim_last;
    db_state_t  state_q;
    cnt_t       db_cnt_q;
    logic       dir_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            btn_m_q <= i_btn;
            btn_s_q <= btn_m_q;
        end
    end

    always_comb begin
        lim_last = LAST0;
        unique case (i_sw[2:1])
            2'b00: lim_last = LAST0;
            2'b01: lim_last = LAST1;
            2'b10: lim_last = LAST2;
            2'b11: lim_last = LAST3;
            default: lim_last = LAST0;
        endcase
    end

    // A selection change restarts the period; disabling only freezes it.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (i_sw[2:1] != sel_q) begin
            cnt_d = '0;
        end else if (i_sw[0]) begin
            if (cnt_q == lim_last) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sel_q   <= i_sw[2:1];
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= i_sw[2:1];
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        state_q  <= WAIT_PRESS;
                        db_cnt_q <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= TOGGLE;
                    end else begin
                        db_cnt_q <= db_cnt_q + cnt_t'(1);
                    end
                end
                TOGGLE: begin
                    dir_q   <= ~dir_q;
                    state_q <= HELD;
                end
                HELD: begin
                    if (!btn_s_q) begin
                        state_q  <= WAIT_REL;
                        db_cnt_q <= '0;
                    end
                end
                WAIT_REL: begin
                    if (btn_s_q) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        db_cnt_q <= db_cnt_q + cnt_t'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_dir   = dir_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: fixed vector table, hand-built corner sequences
// and random traffic against a cycle-level reference model.
module tb_shift_ctrl;

    localparam int NB = 8;
    localparam int L0 = 4;
    localparam int L1 = 6;
    localparam int L2 = 8;
    localparam int L3 = 1;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw;
    logic       btn;
    logic       o_valid;
    logic       o_dir;

    int total = 0;
    int bad   = 0;

    shift_ctrl #(
        .NB_COUNT (NB),
        .LIMIT0   (L0),
        .LIMIT1   (L1),
        .LIMIT2   (L2),
        .LIMIT3   (L3),
        .DB_CYCLES(DB)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .i_sw   (sw),
        .i_btn  (btn),
        .o_valid(o_valid),
        .o_dir  (o_dir)
    );

    always #5 clk = ~clk;

    // Reference model: period counted as enabled cycles since restart,
    // button acceptance counted as run lengths of the synchronized level.
    int         en_cyc;
    logic [1:0] sel_prev;
    logic       m_v;
    logic       m_d;
    logic [1:0] hb;
    logic       held;
    logic       pend;
    int         run;

    function automatic int lim(logic [1:0] s);
        case (s)
            2'b00:   return L0;
            2'b01:   return L1;
            2'b10:   return L2;
            default: return L3;
        endcase
    endfunction

    task automatic model_edge();
        logic s;
        if (!rst_n) begin
            en_cyc   = 0;
            sel_prev = sw[2:1];
            m_v      = 1'b0;
            m_d      = 1'b0;
            hb       = 2'b00;
            held     = 1'b0;
            pend     = 1'b0;
            run      = 0;
        end else begin
            if (sw[2:1] != sel_prev) begin
                en_cyc = 0;
                m_v    = 1'b0;
            end else if (sw[0]) begin
                en_cyc++;
                m_v = ((en_cyc % lim(sw[2:1])) == 0);
            end else begin
                m_v = 1'b0;
            end
            sel_prev = sw[2:1];
            s  = hb[1];
            hb = {hb[0], btn};
            if (pend) begin
                m_d  = ~m_d;
                pend = 1'b0;
                held = 1'b1;
                run  = 0;
            end else if (!held) begin
                run = s ? run + 1 : 0;
                if (run == DB + 1) begin
                    pend = 1'b1;
                    run  = 0;
                end
            end else begin
                run = !s ? run + 1 : 0;
                if (run == DB + 1) begin
                    held = 1'b0;
                    run  = 0;
                end
            end
        end
    endtask

    task automatic chk(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", o_valid, m_v);
        chk("model_dir", o_dir, m_d);
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] sw;
        logic       btn;
        logic       v;
        logic       d;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic r, logic [2:0] s, logic b, logic v, int n = 1);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.rst = r;
            e.sw  = s;
            e.btn = b;
            e.v   = v;
            e.d   = 1'b0;
            tbl.push_back(e);
        end
    endtask

    logic pat[$];
    logic prev_d;
    int   ntog;
    int   btn_left;

    initial begin
        // reset, run at period 4, pause at count 2, resume, reselect
        add(0, 3'b001, 0, 0);
        add(1, 3'b001, 0, 0, 3);
        add(1, 3'b001, 0, 1);
        add(1, 3'b001, 0, 0, 3);
        add(1, 3'b001, 0, 1);
        add(1, 3'b001, 0, 0, 2);
        add(1, 3'b000, 0, 0, 10);
        add(1, 3'b001, 0, 0);
        add(1, 3'b001, 0, 1);
        add(1, 3'b001, 0, 0);
        add(1, 3'b011, 0, 0, 6);
        add(1, 3'b011, 0, 1);
        add(1, 3'b011, 0, 0, 5);
        add(1, 3'b011, 0, 1);
        add(1, 3'b111, 0, 0);
        add(1, 3'b111, 0, 1, 5);

        rst_n = 1'b0;
        sw    = 3'b001;
        btn   = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst;
            sw    = tbl[i].sw;
            btn   = tbl[i].btn;
            step();
            chk($sformatf("tbl_valid[%0d]", i), o_valid, tbl[i].v);
            chk($sformatf("tbl_dir[%0d]", i), o_dir, tbl[i].d);
        end

        // clean long press toggles once, 7 edges after the rise
        rst_n = 1'b0;
        sw    = 3'b000;
        btn   = 1'b0;
        step();
        rst_n = 1'b1;
        btn   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("press_dir[%0d]", i), o_dir, logic'(i >= 7));
        end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) step();
        btn = 1'b1;
        step();
        step();
        btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("glitch_dir", o_dir, 1'b1);
        end

        // bouncy press and release, then a clean second press
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pat = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1,
                0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 1, 1, 1, 1, 1, 1, 1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        prev_d = o_dir;
        ntog   = 0;
        foreach (pat[i]) begin
            btn = pat[i];
            step();
            if (o_dir !== prev_d) ntog++;
            prev_d = o_dir;
        end
        total++;
        if (ntog != 2) begin
            bad++;
            $display("FAIL bounce_toggles: got %0d want 2", ntog);
        end
        chk("bounce_final_dir", o_dir, 1'b0);

        // reset mid-debounce and mid-period
        sw  = 3'b001;
        btn = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_dir", o_dir, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("post_rst_valid[%0d]", i), o_valid, logic'(i % 4 == 0));
            chk($sformatf("post_rst_dir[%0d]", i), o_dir, logic'(i >= 7));
        end

        // random traffic
        btn_left = 0;
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 79) == 0) sw[2:1] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 23) == 0) sw[0] = ~sw[0];
            if (btn_left == 0) begin
                btn      = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 8);
            end
            btn_left--;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
